// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned CHK_BYTES  = 1;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } boot_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses one
// cycle after the fourth byte of a word is shifted in.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] din,
  output logic              last_byte,
  output logic              word_valid,
  output logic [31:0]       word
);

  logic [1:0]  idx;
  logic [31:0] sr;

  assign last_byte = (idx == 2'(WORD_BYTES - 1));
  assign word      = sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      idx        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift_en && last_byte;
      if (shift_en) begin
        idx <= idx + 2'd1;
        sr  <= {sr[31-BYTE_W:0], din};
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a checksummed program image into instruction memory and holds the
// core in reset until the image has been loaded and verified.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_rst_n,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  boot_state_e state, state_next;

  logic [7:0]  hdr_hi;
  logic [7:0]  run_xor;
  logic [15:0] word_cnt;
  logic [15:0] hdr_n;
  logic        xfer;
  logic        rearm;
  logic        shift_en;
  logic        last_byte;
  logic        last_word;

  assign byte_ready = (state != DONE) && (state != ERROR);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign xfer       = byte_valid && byte_ready;
  assign rearm      = start && !byte_ready;
  assign hdr_n      = {hdr_hi, byte_data};
  assign shift_en   = xfer && (state == DATA);
  assign last_word  = (words_loaded + 16'd1) == word_cnt;

  boot_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (rearm),
    .shift_en  (shift_en),
    .din       (byte_data),
    .last_byte (last_byte),
    .word_valid(imem_we),
    .word      (imem_wd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR_HI;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HDR_HI: if (xfer) state_next = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (32'(hdr_n) > DEPTH) state_next = ERROR;
          else if (hdr_n == '0)   state_next = CHECK;
          else                    state_next = DATA;
        end
      end
      DATA:        if (shift_en && last_byte && last_word) state_next = CHECK;
      CHECK:       if (xfer) state_next = (byte_data == run_xor) ? DONE : ERROR;
      DONE, ERROR: if (start) state_next = HDR_HI;
      default:     state_next = HDR_HI;
    endcase
  end

  // Count and address update on the edge of the word's last byte, so the
  // write cycle shows the incremented count beside the pre-increment address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_hi       <= '0;
      run_xor      <= '0;
      word_cnt     <= '0;
      words_loaded <= '0;
      imem_addr    <= BASE_ADDR;
      core_rst_n   <= 1'b0;
    end else begin
      core_rst_n <= (state == DONE) && (state_next == DONE);
      if (rearm) begin
        hdr_hi       <= '0;
        run_xor      <= '0;
        word_cnt     <= '0;
        words_loaded <= '0;
        imem_addr    <= BASE_ADDR;
      end else begin
        if (xfer)                     run_xor  <= run_xor ^ byte_data;
        if (xfer && state == HDR_HI)  hdr_hi   <= byte_data;
        if (xfer && state == HDR_LO)  word_cnt <= hdr_n;
        if (shift_en && last_byte) begin
          words_loaded <= words_loaded + 16'd1;
          imem_addr    <= word_addr(BASE_ADDR, words_loaded);
        end
      end
    end
  end

endmodule
